// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_div(op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step over the {hi, lo} register pair.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    diff = {hi, lo[XLEN-1]} - {1'b0, m};
    if (div) begin
      // Partial remainder is always below the divisor, so XLEN bits suffice
      if (!diff[XLEN]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = {hi[XLEN-2:0], lo[XLEN-1]};
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle, registered
// result with zero/neg flags, valid/ready on both sides, flush abort.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            neg
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_reg, state_next;
  op_e             op_reg;
  logic [XLEN-1:0] a_reg, b_reg, hi_reg, lo_reg, result_reg;
  logic            s1_reg, s2_reg, zero_reg, neg_reg;
  logic [CW-1:0]   cnt_reg;

  logic            s1_w, s2_w, div0, ovf, spec_hit;
  logic [XLEN-1:0] spec_val, fix_val, step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;

  assign in_ready  = (state_reg == S_IDLE) && !flush;
  assign out_valid = (state_reg == S_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign neg       = neg_reg;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div     (is_div(op_reg)),
    .hi      (hi_reg),
    .lo      (lo_reg),
    .m       (b_reg),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Sign capture and divide corner cases, evaluated in PREP on raw operands
  always_comb begin
    s1_w = a_reg[XLEN-1] && (op_reg == OP_MULH || op_reg == OP_MULHSU ||
                             op_reg == OP_DIV  || op_reg == OP_REM);
    s2_w = b_reg[XLEN-1] && (op_reg == OP_MULH || op_reg == OP_DIV ||
                             op_reg == OP_REM);
    div0 = (b_reg == '0);
    ovf  = (op_reg == OP_DIV || op_reg == OP_REM) && (a_reg == MIN_NEG) && (&b_reg);
    spec_hit = is_div(op_reg) && (div0 || ovf);
    if (div0)
      spec_val = (op_reg == OP_DIV || op_reg == OP_DIVU) ? '1 : a_reg;
    else
      spec_val = (op_reg == OP_DIV) ? a_reg : '0;
  end

  always_comb begin
    prod   = {hi_reg, lo_reg};
    prod_s = (s1_reg ^ s2_reg) ? -prod : prod;
    case (op_reg)
      OP_MUL:                     fix_val = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            fix_val = (s1_reg ^ s2_reg) ? -lo_reg : lo_reg;
      default:                    fix_val = s1_reg ? -hi_reg : hi_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (in_valid && in_ready) state_next = S_PREP;
      S_PREP: state_next = spec_hit ? S_DONE : S_CALC;
      S_CALC: if (cnt_reg == LAST) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg     <= OP_MUL;
      a_reg      <= '0;
      b_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (in_valid && in_ready) begin
          op_reg <= op_e'(op);
          a_reg  <= rs1;
          b_reg  <= rs2;
        end
        S_PREP: begin
          s1_reg  <= s1_w;
          s2_reg  <= s2_w;
          hi_reg  <= '0;
          lo_reg  <= s1_w ? -a_reg : a_reg;
          b_reg   <= s2_w ? -b_reg : b_reg;
          cnt_reg <= '0;
          if (spec_hit) begin
            result_reg <= spec_val;
            zero_reg   <= (spec_val == '0);
            neg_reg    <= spec_val[XLEN-1];
          end
        end
        S_CALC: begin
          hi_reg  <= step_hi;
          lo_reg  <= step_lo;
          cnt_reg <= cnt_reg + CW'(1);
        end
        S_FIX: begin
          result_reg <= fix_val;
          zero_reg   <= (fix_val == '0);
          neg_reg    <= fix_val[XLEN-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        neg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg)
  );

  // Present one operation for a single accepting edge; returns #1 after it.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges after acceptance until out_valid is seen; -1 when the bound expires.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, result, zero, neg} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b res=%h z=%b n=%b expected 1 0 00000000 0 0",
               in_ready, out_valid, result, zero, neg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_mul();
    int lat;
    start_op(3'd0, 32'd7, 32'hFFFFFFFD);
    wait_out(lat);
    checks++;
    if (lat !== 34) begin
      errors++; $display("FAIL mul_latency: got %0d expected 34", lat);
    end
    checks++;
    if ({result, neg, zero} !== {32'hFFFFFFEB, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mul: res=%h n=%b z=%b expected ffffffeb 1 0", result, neg, zero);
    end
    $display("MUL 7 x fffffffd -> %h lat=%0d", result, lat);
    consume();
  endtask

  task automatic test_mulh();
    logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
    logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002};
    logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_out(lat);
      checks++;
      if (lat !== 34 || result !== exp[i]) begin
        errors++;
        $display("FAIL mulh_%0d: res=%h lat=%0d expected %h lat=34", i, result, lat, exp[i]);
      end
      $display("op%0d %h x %h -> %h", ops[i], as[i], bs[i], result);
      consume();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], 32'hFFFFFFF9, 32'd2);
      wait_out(lat);
      checks++;
      if (lat !== 34 || result !== exp[i] || neg !== exp[i][31]) begin
        errors++;
        $display("FAIL div_%0d: res=%h n=%b lat=%0d expected %h lat=34", i, result, neg, lat, exp[i]);
      end
      $display("op%0d fffffff9 / 2 -> %h", ops[i], result);
      consume();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(3'd4, 32'd5, 32'd0);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_by_zero: res=%h lat=%0d expected ffffffff lat=1", result, lat);
    end
    $display("DIV 5 / 0 -> %h lat=%0d", result, lat);
    consume();
    start_op(3'd7, 32'd5, 32'd0);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 32'd5) begin
      errors++; $display("FAIL remu_by_zero: res=%h lat=%0d expected 00000005 lat=1", result, lat);
    end
    $display("REMU 5 / 0 -> %h lat=%0d", result, lat);
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    start_op(3'd4, 32'h80000000, 32'hFFFFFFFF);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 32'h80000000 || neg !== 1'b1) begin
      errors++; $display("FAIL div_ovf: res=%h n=%b lat=%0d expected 80000000 1 lat=1", result, neg, lat);
    end
    $display("DIV ovf -> %h", result);
    consume();
    start_op(3'd6, 32'h80000000, 32'hFFFFFFFF);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 32'h0 || zero !== 1'b1) begin
      errors++; $display("FAIL rem_ovf: res=%h z=%b lat=%0d expected 00000000 1 lat=1", result, zero, lat);
    end
    $display("REM ovf -> %h zero=%b", result, zero);
    consume();
  endtask

  task automatic test_hold();
    int lat;
    start_op(3'd0, 32'd1000, 32'd1000);
    wait_out(lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd1000000) begin
        errors++;
        $display("FAIL hold_%0d: vld=%b rdy=%b res=%h expected 1 0 000f4240", c, out_valid, in_ready, result);
      end
    end
    $display("hold 5 cycles -> %h", result);
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    start_op(3'd0, 32'd9, 32'd9);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready_low: rdy=%b expected 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle: rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_no_output: out_valid rose=%b expected 0", seen);
    end
    $display("flush at CALC cycle 10 -> idle");
  endtask

  task automatic test_reset_mid();
    start_op(3'd0, 32'd6, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, result, zero, neg} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b res=%h z=%b n=%b expected 1 0 00000000 0 0",
               in_ready, out_valid, result, zero, neg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("async reset mid-CALC");
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(3'd0, 32'd3, 32'd4);
    wait_out(lat);
    checks++;
    if (lat !== 34 || result !== 32'd12) begin
      errors++; $display("FAIL mul_3x4: res=%h lat=%0d expected 0000000c lat=34", result, lat);
    end
    $display("MUL 3 x 4 -> %h", result);
    consume();
    start_op(3'd5, 32'd100, 32'd7);
    wait_out(lat);
    checks++;
    if (lat !== 34 || result !== 32'd14) begin
      errors++; $display("FAIL b2b_divu: res=%h lat=%0d expected 0000000e lat=34", result, lat);
    end
    $display("DIVU 100 / 7 -> %h", result);
    consume();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_zero();
    test_overflow();
    test_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit for the execute stage, implementing the eight RV32M operations alongside the single-cycle integer ALU. It accepts one operation at a time over a valid/ready handshake and spends one cycle per operand bit. It presents a registered result with zero/neg flags matching the ALU flag semantics. The result is held until the downstream stage takes it. Pipeline flush and asynchronous reset abort any in-flight operation.

## Interface
- XLEN, 32: operand and result width; must be ≥ 8 and a power of two.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous assertion, active-low.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  operation present on op/rs1/rs2.
- in_ready  out  1  unit can accept; high only in IDLE and when flush is low.
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1, rs2  in  XLEN  operands; rs1 is the multiplicand/dividend.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- result  out  XLEN  registered result.
- zero  out  1  registered; result == 0.
- neg  out  1  registered; result[XLEN-1].

## Operation
- States: IDLE, PREP, CALC, FIX, DONE. Reset state is IDLE.
- IDLE:
  - An operation is accepted when in_valid && in_ready.
  - On acceptance, op, rs1 and rs2 are latched and the state moves to PREP.
- PREP (one cycle):
  - Records the signs: rs1 is signed for MULH, MULHSU and the signed divide/remainder ops; rs2 is signed for MULH and the signed divide/remainder ops.
  - Loads operand magnitudes.
  - Clears the iteration counter and goes to CALC.
  - Special divides go straight to DONE with the result loaded, skipping CALC and FIX:
    - rs2 == 0: DIV/DIVU → all-ones; REM/REMU → rs1.
    - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all-ones): DIV → rs1; REM → 0.
- CALC (exactly XLEN cycles, one bit per cycle):
  - Multiply: shift-add into a 2·XLEN unsigned product.
  - Divide: restoring divide producing an XLEN quotient and an XLEN remainder.
  - The counter has $clog2(XLEN)+1 bits; leave CALC when the counter reaches XLEN-1.
- FIX (one cycle):
  - Multiply sign correction: negate the 2·XLEN product if the operand signs differ. MUL takes the low half; MULH, MULHSU and MULHU take the high half.
  - Divide sign correction: the quotient sign is s1^s2; the remainder sign follows the dividend.
  - Loads result, zero and neg, then goes to DONE.
- DONE:
  - out_valid is high.
  - result, zero and neg are stable until the handshake.
  - On out_valid && out_ready the state returns to IDLE.
- Flush: from any state, go to IDLE on the next edge with out_valid low. While flush is high, in_ready is low and in_valid is ignored.
- Arithmetic is modulo 2^XLEN. There are no exceptions.

## Timing
- Reset values: in_ready 1, out_valid 0, result 0, zero 0, neg 0. All internal registers are cleared.
- Normal latency: acceptance at edge 0 gives out_valid high after edge XLEN+2 (34 for XLEN=32).
- Special divide latency: out_valid high after edge 1.
- The unit is not pipelined. The next acceptance is no earlier than the edge after the output handshake.
- If out_ready is already high when out_valid rises, the output is consumed in that same cycle.
- If flush and out_ready are both high in DONE, flush wins. The result is dropped; downstream must treat it as consumed only if flush is low.
- Reset asserted mid-operation returns the unit to reset values immediately.

## Structure
- Package muldiv_pkg holds:
  - the op_e enum, using the funct3 values above;
  - the state_e enum;
  - the helper function is_div(op).
- Sub-module muldiv_step: a combinational single-iteration unit (one shift-add or one restore-subtract step), instantiated once. The FSM, counter and registers stay in muldiv_unit.

## Test plan
All values use XLEN=32.
- MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB, neg=1, zero=0; out_valid rises exactly 34 edges after acceptance.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU same operands → 1.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with out_valid after 1 edge.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0, zero=1.
- Control:
  - Hold out_ready low for 5 cycles in DONE → result stable and in_ready low throughout.
  - Assert flush at CALC cycle 10 → IDLE next edge, out_valid never rises.
  - Assert reset_n low mid-CALC → outputs return to reset values without waiting for a clock edge.
  - A subsequent MUL 3×4 returns 12.
